argmax_readout: RTL and testbench
=================================

ARGMAX_READOUT -- requirements
Module: argmax_readout

Interface
REQ-001 SHALL have parameter FM_WM_ROWS, default 6: number of node rows in the combined output matrix.
REQ-002 SHALL have parameter FM_WM_COLS, default 3: number of class columns per row; the block supports exactly 3.
REQ-003 SHALL have parameter DOT_PROD_WIDTH, default 16: width of each matrix element.
REQ-004 SHALL have parameter FM_WM_WIDTH, default $clog2(FM_WM_ROWS): row address width.
REQ-005 SHALL have parameter MAX_ADDRESS_WIDTH, default $clog2(FM_WM_COLS): width of one class index.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: level from the upstream combination stage, meaning the matrix is complete and readable.
REQ-009 SHALL have port fm_wm_adj_out, input, unpacked [0:FM_WM_COLS-1] of DOT_PROD_WIDTH bits: row data for the current address, valid in the same cycle (combinational read).
REQ-010 SHALL have port fm_wm_adj_row, output, FM_WM_WIDTH bits: read row address into the combination-stage memory.
REQ-011 SHALL have port max_addi_answer, output, unpacked [0:FM_WM_ROWS-1] of MAX_ADDRESS_WIDTH bits: per-row argmax class index.
REQ-012 SHALL have port done, output, 1 bit: all rows classified and max_addi_answer is final.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, SCAN and DONE, plus a row counter of FM_WM_WIDTH bits.
REQ-014 In IDLE with start=1 at a rising edge: the FSM SHALL move to SCAN and the row counter SHALL become 0; with start=0 it SHALL remain in IDLE.
REQ-015 In SCAN, fm_wm_adj_row SHALL equal the row counter; in IDLE and DONE, fm_wm_adj_row SHALL be 0.
REQ-016 In each SCAN cycle, the block SHALL compare the three elements of fm_wm_adj_out as unsigned values and register the argmax index into max_addi_answer[row] at the rising edge.
REQ-017 On ties, the lowest column index SHALL win (e.g. {5,5,2} -> 0; {1,7,7} -> 1).
REQ-018 In SCAN, if row == FM_WM_ROWS-1, the FSM SHALL move to DONE on the same edge that writes the last answer; otherwise row SHALL increment by 1.
REQ-019 The row counter SHALL never exceed FM_WM_ROWS-1; there SHALL be no wrap-around within one scan.
REQ-020 done SHALL be 1 only in DONE, as a registered state decode.
REQ-021 Latency: with start sampled at edge E0, rows 0..5 SHALL be written at edges E1..E6 and done SHALL be high from E6 onward.
REQ-022 Changes on start during SCAN SHALL be ignored; the scan always completes all rows.
REQ-023 In DONE, done and answers SHALL be held while start=1.
REQ-024 In DONE with start=0, the FSM SHALL return to IDLE; done SHALL fall and answers SHALL be retained.
REQ-025 A new start from IDLE SHALL rescan and overwrite every answer entry.
REQ-026 max_addi_answer entries SHALL change only at SCAN write edges or on reset.

Reset
REQ-027 While reset=0, asynchronously and regardless of clk: the FSM SHALL enter IDLE, the row counter SHALL be 0, every max_addi_answer entry SHALL be 0, done SHALL be 0 and fm_wm_adj_row SHALL be 0.
REQ-028 Reset asserted mid-SCAN SHALL abort the scan immediately; after release, the block SHALL wait in IDLE for start.
REQ-029 Reset release SHALL take effect at the next rising edge; start=1 at that edge SHALL begin a scan.

Verification
REQ-030 Basic scan: rows {1,9,3},{8,2,2},{0,0,4},{7,7,7},{2,6,9},{10,3,1}, start pulsed high -> answers {1,0,2,0,2,0}; done rises 6 edges after start; fm_wm_adj_row sequence 0..5.
REQ-031 Ties and extremes: rows {FFFF,FFFF,0},{0,FFFF,FFFF},{0,0,0} -> answers 0,1,0; confirms unsigned compare (FFFF > 7FFF).
REQ-032 Start handling: start held high through SCAN and DONE -> single scan, done stays 1; start dropped -> IDLE, done=0, answers unchanged.
REQ-033 Reset mid-operation: reset=0 asserted after row 2 is written -> immediately all answers=0, done=0, address=0; new start after release -> full rescan with correct results.
REQ-034 Rescan: second start with different data -> every answer entry updated; no stale values remain.
REQ-035 Idle stability: start=0 for 20 cycles after reset -> fm_wm_adj_row=0, done=0, answers=0 throughout.

Source files
------------

// File: rtl/argmax_readout.sv
// Per-row argmax readout: walks every row of the combined matrix once per start and
// records the index of the largest (unsigned) class score, lowest index winning ties.
module argmax_readout #(
    parameter int unsigned FM_WM_ROWS        = 6,
    parameter int unsigned FM_WM_COLS        = 3,
    parameter int unsigned DOT_PROD_WIDTH    = 16,
    parameter int unsigned FM_WM_WIDTH       = $clog2(FM_WM_ROWS),
    parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(FM_WM_COLS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DOT_PROD_WIDTH-1:0]    fm_wm_adj_out   [0:FM_WM_COLS-1],
    output logic [FM_WM_WIDTH-1:0]       fm_wm_adj_row,
    output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FM_WM_ROWS-1],
    output logic                         done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [FM_WM_WIDTH-1:0] LastRow = FM_WM_WIDTH'(FM_WM_ROWS - 1);

    state_e                         state_q, state_d;
    logic [FM_WM_WIDTH-1:0]         row_q, row_d;
    logic [MAX_ADDRESS_WIDTH-1:0]   ans_q [0:FM_WM_ROWS-1];
    logic [MAX_ADDRESS_WIDTH-1:0]   ans_d [0:FM_WM_ROWS-1];
    logic [MAX_ADDRESS_WIDTH-1:0]   best_idx;
    logic [DOT_PROD_WIDTH-1:0]      best_val;

    // Strict greater-than keeps the earliest column on ties.
    always_comb begin
        best_idx = '0;
        best_val = fm_wm_adj_out[0];
        for (int c = 1; c < int'(FM_WM_COLS); c++) begin
            if (fm_wm_adj_out[c] > best_val) begin
                best_val = fm_wm_adj_out[c];
                best_idx = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        ans_d   = ans_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    row_d   = '0;
                end
            end
            StScan: begin
                for (int r = 0; r < int'(FM_WM_ROWS); r++) begin
                    if (row_q == FM_WM_WIDTH'(r)) begin
                        ans_d[r] = best_idx;
                    end
                end
                if (row_q == LastRow) begin
                    state_d = StDone;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            for (int r = 0; r < int'(FM_WM_ROWS); r++) begin
                ans_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ans_q   <= ans_d;
        end
    end

    assign fm_wm_adj_row   = (state_q == StScan) ? row_q : '0;
    assign done            = (state_q == StDone);
    assign max_addi_answer = ans_q;

endmodule

// File: tb/tb_argmax_readout.sv
// Scoreboarded random/directed bench for argmax_readout with a behavioural argmax model.
module tb_argmax_readout;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int W    = 16;
    localparam int AW   = $clog2(ROWS);
    localparam int IW   = $clog2(COLS);

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  fm_wm_adj_out   [0:COLS-1];
    logic [AW-1:0] fm_wm_adj_row;
    logic [IW-1:0] max_addi_answer [0:ROWS-1];
    logic          done;

    logic [W-1:0]  mem [ROWS][COLS];

    typedef struct {
        logic [ROWS*IW-1:0] ans;
        int unsigned        due;
    } exp_t;

    exp_t               sb[$];
    int unsigned        n_checks = 0;
    int unsigned        n_fail   = 0;
    int unsigned        cyc      = 0;
    logic [ROWS*IW-1:0] last_ans = '0;

    argmax_readout #(
        .FM_WM_ROWS     (ROWS),
        .FM_WM_COLS     (COLS),
        .DOT_PROD_WIDTH (W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fm_wm_adj_out   (fm_wm_adj_out),
        .fm_wm_adj_row   (fm_wm_adj_row),
        .max_addi_answer (max_addi_answer),
        .done            (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            fm_wm_adj_out[c] = (int'(fm_wm_adj_row) < ROWS) ? mem[fm_wm_adj_row][c] : '0;
        end
    end

    // Model: find the maximum value, then the first column holding it.
    function automatic logic [IW-1:0] ref_argmax(input int r);
        int unsigned m = 0;
        for (int c = 0; c < COLS; c++) if (int'(mem[r][c]) > int'(m)) m = mem[r][c];
        for (int c = 0; c < COLS; c++) if (mem[r][c] == W'(m)) return IW'(c);
        return '0;
    endfunction

    function automatic logic [ROWS*IW-1:0] ref_all();
        logic [ROWS*IW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*IW +: IW] = ref_argmax(r);
        return v;
    endfunction

    function automatic logic [ROWS*IW-1:0] dut_all();
        logic [ROWS*IW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*IW +: IW] = max_addi_answer[r];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_rows(input logic [W-1:0] tbl [ROWS][COLS]);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[r][c] = tbl[r][c];
    endtask

    task automatic load_random(input bit narrow);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = narrow ? W'($urandom_range(0, 3)) : W'($urandom);
    endtask

    task automatic do_scan(input bit hold);
        exp_t e;
        e.ans = ref_all();
        @(negedge clk);
        start = 1'b1;
        e.due = cyc + 7;
        sb.push_back(e);
        for (int i = 0; i < ROWS; i++) begin
            @(negedge clk);
            check("row_addr", 64'(fm_wm_adj_row), 64'(i));
            check("done_during_scan", 64'(done), 64'd0);
            start = hold ? 1'b1 : ((i == ROWS - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
        end
        last_ans = e.ans;
        if (hold) begin
            repeat (4) begin
                @(negedge clk);
                check("done_held", 64'(done), 64'd1);
                check("ans_held", 64'(dut_all()), 64'(last_ans));
            end
            start = 1'b0;
        end
        @(negedge clk);
        if (!hold) check("done_one_cycle", 64'(done), 64'd1);
        if (!hold) @(negedge clk);
        check("done_fell", 64'(done), 64'd0);
        check("idle_addr", 64'(fm_wm_adj_row), 64'd0);
        check("ans_retained", 64'(dut_all()), 64'(last_ans));
    endtask

    // Monitor: pops expected answers whenever done rises.
    initial begin
        exp_t e;
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_answers", 64'(dut_all()), 64'(e.ans));
                    check("sb_done_latency", 64'(cyc), 64'(e.due));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] basic [ROWS][COLS] = '{
            '{16'd1, 16'd9, 16'd3}, '{16'd8, 16'd2, 16'd2}, '{16'd0, 16'd0, 16'd4},
            '{16'd7, 16'd7, 16'd7}, '{16'd2, 16'd6, 16'd9}, '{16'd10, 16'd3, 16'd1}};
        logic [W-1:0] extreme [ROWS][COLS] = '{
            '{16'hFFFF, 16'hFFFF, 16'h0}, '{16'h0, 16'hFFFF, 16'hFFFF}, '{16'h0, 16'h0, 16'h0},
            '{16'h7FFF, 16'hFFFF, 16'h1}, '{16'h5, 16'h5, 16'h2}, '{16'h1, 16'h7, 16'h7}};

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[r][c] = '0;

        #12;
        check("reset_ans", 64'(dut_all()), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_addr", 64'(fm_wm_adj_row), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        repeat (20) begin
            @(negedge clk);
            check("idle_stable", {61'd0, done, 2'(|fm_wm_adj_row), 1'b0} | 64'(dut_all()), 64'd0);
        end

        load_rows(basic);
        check("model_basic", 64'(ref_all()), 64'({2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1}));
        do_scan(1'b0);

        load_rows(extreme);
        check("model_extreme", 64'(ref_all()), 64'({2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0}));
        do_scan(1'b1);

        // Abort a scan with reset after row 2 has been written.
        load_random(1'b0);
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_addr_before", 64'(fm_wm_adj_row), 64'd3);
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("abort_ans", 64'(dut_all()), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_addr", 64'(fm_wm_adj_row), 64'd0);
        last_ans = '0;
        repeat (3) @(negedge clk);
        check("abort_ans_held", 64'(dut_all()), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_abort_idle_addr", 64'(fm_wm_adj_row), 64'd0);
        check("post_abort_idle_done", 64'(done), 64'd0);
        do_scan(1'b0);

        for (int k = 0; k < 8; k++) begin
            load_random(k[0]);
            do_scan(k[1]);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
